// File: rtl/hc595_arb_pkg.sv
// Shared types and sizing helpers for the HC595 chain arbiter.
// Holds the FSM state enum, counter-width helpers and the frame-period formula.
package hc595_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  function automatic int div_cnt_w(input int clk_div);
    return $clog2(clk_div + 1);
  endfunction

  function automatic int bit_cnt_w(input int frame_w);
    return (frame_w > 1) ? $clog2(frame_w) : 1;
  endfunction

  // Cycles from the req-sampling IDLE cycle to the next IDLE cycle.
  function automatic int frame_period(input int frame_w, input int clk_div);
    return 1 + 2 * clk_div * frame_w + clk_div;
  endfunction

  localparam int DEF_FRAME_PERIOD = frame_period(16, 4);

endpackage

// File: rtl/hc595_chain_arbiter_if.sv
// Producer-side bus of the HC595 chain arbiter: requests, frames and grant status.
interface hc595_chain_arbiter_if #(
  parameter int NREQ    = 2,
  parameter int FRAME_W = 16
);
  // Handshake: a producer raises req[i] with its frame stable and holds both until
  // ack[i] pulses for one cycle; the frame is sampled in the cycle before that ack,
  // after which req and frame may change freely. Dropping req before ack withdraws it.
  logic [NREQ-1:0]          req;
  logic [NREQ*FRAME_W-1:0]  frame;
  logic [NREQ-1:0]          ack;
  logic [$clog2(NREQ)-1:0]  grant_id;
  logic                     busy;
  logic                     done;

  modport master (output req, frame, input ack, grant_id, busy, done);
  modport slave  (input req, frame, output ack, grant_id, busy, done);
endinterface

// File: rtl/hc595_arb_pick.sv
// Winner selection over req: round-robin with a last-winner pointer by default,
// or a lowest-index priority encoder when HC595_ARB_FIXED_PRIO_EN is defined.
module hc595_arb_pick #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic                    grant_en,
  output logic                    any_req,
  output logic [$clog2(NREQ)-1:0] winner
);
  localparam int IW = $clog2(NREQ);

  assign any_req = |req;

`ifdef HC595_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) winner = IW'(i);
    end
  end
`else
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          found;

  // Pointer starts at NREQ-1 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         ptr <= IW'(NREQ - 1);
    else if (grant_en) ptr <= winner;
  end

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/hc595_chain_arbiter.sv
// Shares one 74HC595 chain among NREQ frame producers: grants one frame, shifts it
// MSB-first on sck/ser, then pulses rck. Fixed priority with HC595_ARB_FIXED_PRIO_EN.
module hc595_chain_arbiter
  import hc595_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  hc595_chain_arbiter_if.slave  bus,
  output logic                  sck,
  output logic                  rck,
  output logic                  ser,
  output state_t                dbg_state
);
  localparam int IW = $clog2(NREQ);
  localparam int DW = div_cnt_w(CLK_DIV);
  localparam int BW = bit_cnt_w(FRAME_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);

  state_t               state, state_d;
  logic [DW-1:0]        div_cnt, div_cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic                 phase_hi, phase_hi_d;
  logic [FRAME_W-1:0]   shreg, shreg_d;
  logic                 sck_d, rck_d, ser_d, busy_d, done_d, busy_q, done_q;
  logic [NREQ-1:0]      ack_d, ack_q;
  logic [IW-1:0]        grant_d, grant_q;
  logic                 any_req, grant_en;
  logic [IW-1:0]        winner;
  logic [FRAME_W-1:0]   frames [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign frames[g] = bus.frame[g*FRAME_W +: FRAME_W];
  end

  assign grant_en = (state == IDLE) && any_req;

  hc595_arb_pick #(.NREQ(NREQ)) u_pick (
    .clk      (clk),
    .rstn     (rstn),
    .req      (bus.req),
    .grant_en (grant_en),
    .any_req  (any_req),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase_hi <= 1'b0;
      shreg    <= '0;
      sck      <= 1'b0;
      rck      <= 1'b0;
      ser      <= 1'b0;
      ack_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      phase_hi <= phase_hi_d;
      shreg    <= shreg_d;
      sck      <= sck_d;
      rck      <= rck_d;
      ser      <= ser_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Each bit spends CLK_DIV cycles with sck low, then CLK_DIV with sck high;
  // the shift register only advances after the high phase so ser never moves under a rising sck.
  always_comb begin
    state_d    = state;
    div_cnt_d  = div_cnt;
    bit_cnt_d  = bit_cnt;
    phase_hi_d = phase_hi;
    shreg_d    = shreg;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_d    = SHIFT;
          div_cnt_d  = '0;
          phase_hi_d = 1'b0;
          bit_cnt_d  = BIT_LAST;
          shreg_d    = frames[winner];
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d  = '0;
          phase_hi_d = ~phase_hi;
          if (phase_hi) begin
            if (bit_cnt == '0) begin
              state_d = LATCH;
            end else begin
              bit_cnt_d = bit_cnt - BW'(1);
              shreg_d   = {shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the next state and registered, so the chain sees clean edges.
  always_comb begin
    sck_d   = (state_d == SHIFT) && phase_hi_d;
    ser_d   = (state_d == SHIFT) ? shreg_d[FRAME_W-1] : 1'b0;
    rck_d   = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == LATCH) && (div_cnt_d == DIV_LAST);
    ack_d   = '0;
    grant_d = grant_q;
    if (grant_en) begin
      ack_d[winner] = 1'b1;
      grant_d       = winner;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_hc595_chain_arbiter.sv
// Directed bench for hc595_chain_arbiter: a CLK_DIV=4 and a CLK_DIV=1 instance,
// each driving a small model of an HC595 chain (shift on sck rise, latch on rck rise).
module tb_hc595_chain_arbiter;
  import hc595_arb_pkg::*;

  typedef struct {
    int          sel;     // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
    logic [1:0]  req;
    logic [15:0] f0;
    logic [15:0] f1;
    bit          drop;    // drop req after ack and check a quiet idle afterwards
    bit          glitch;  // pulse req[1] while busy, withdrawn before IDLE
    int          grant;   // expected winner
  } vec_t;

`ifdef HC595_ARB_FIXED_PRIO_EN
  localparam int G_ALT = 0;
`else
  localparam int G_ALT = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hc595_chain_arbiter_if #(.NREQ(2), .FRAME_W(16)) bus0 ();
  hc595_chain_arbiter_if #(.NREQ(2), .FRAME_W(16)) bus1 ();
  logic   sck0, rck0, ser0, sck1, rck1, ser1;
  state_t st0, st1;

  hc595_chain_arbiter #(.NREQ(2), .FRAME_W(16), .CLK_DIV(4)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0), .sck(sck0), .rck(rck0), .ser(ser0), .dbg_state(st0)
  );
  hc595_chain_arbiter #(.NREQ(2), .FRAME_W(16), .CLK_DIV(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1), .sck(sck1), .rck(rck1), .ser(ser1), .dbg_state(st1)
  );

  // external HC595 chain models
  logic [15:0] sr0 = '0, lat0 = '0, sr1 = '0, lat1 = '0;
  int          rck_rises0 = 0;
  always @(posedge sck0) sr0 <= {sr0[14:0], ser0};
  always @(posedge rck0) begin
    lat0       <= sr0;
    rck_rises0 <= rck_rises0 + 1;
  end
  always @(posedge sck1) sr1 <= {sr1[14:0], ser1};
  always @(posedge rck1) lat1 <= sr1;

  // observation mux
  int          sel = 0;
  logic        o_sck, o_ser, o_rck, o_busy, o_done, o_gid;
  logic [1:0]  o_ack;
  logic [15:0] o_lat;
  state_t      o_st;
  assign o_sck  = (sel != 0) ? sck1 : sck0;
  assign o_ser  = (sel != 0) ? ser1 : ser0;
  assign o_rck  = (sel != 0) ? rck1 : rck0;
  assign o_busy = (sel != 0) ? bus1.busy : bus0.busy;
  assign o_done = (sel != 0) ? bus1.done : bus0.done;
  assign o_gid  = (sel != 0) ? bus1.grant_id : bus0.grant_id;
  assign o_ack  = (sel != 0) ? bus1.ack : bus0.ack;
  assign o_lat  = (sel != 0) ? lat1 : lat0;
  assign o_st   = (sel != 0) ? st1 : st0;

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int s, input logic [1:0] r);
    if (s != 0) bus1.req = r;
    else        bus0.req = r;
  endtask

  // driver: called at a negedge; that cycle is cycle 0 (req sampled at its closing edge)
  task automatic run_vec(input vec_t v, input int id);
    int          div, p, shift_end, wave_bad, ack_bad, rises, idle_bad;
    logic [15:0] fexp, bits;
    logic [1:0]  ack_first;
    logic        gid_first, prev_sck, e_sck, e_ser, e_rck, e_done, e_busy;
    logic [3:0]  bi;
    state_t      st_end;
    div       = (v.sel != 0) ? 1 : 4;
    p         = frame_period(16, div);
    shift_end = 2 * div * 16;
    fexp      = (v.grant == 1) ? v.f1 : v.f0;
    sel       = v.sel;
    if (v.sel != 0) bus1.frame = {v.f1, v.f0};
    else            bus0.frame = {v.f1, v.f0};
    set_req(v.sel, v.req);
    wave_bad = 0; ack_bad = 0; rises = 0; bits = '0; prev_sck = 1'b0;
    ack_first = '0; gid_first = 1'b0; st_end = IDLE;
    for (int c = 1; c <= p; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ack_first = o_ack;
        gid_first = o_gid;
        if (v.drop) set_req(v.sel, 2'b00);
      end else if (o_ack != 2'b00) begin
        ack_bad++;
      end
      if (v.glitch && v.sel == 0 && c == 10)  bus0.req[1] = 1'b1;
      if (v.glitch && v.sel == 0 && c == 100) bus0.req[1] = 1'b0;
      bi     = 4'(15 - (c - 1) / (2 * div));
      e_sck  = (c <= shift_end) && (((c - 1) / div) % 2 == 1);
      e_ser  = (c <= shift_end) ? fexp[bi] : 1'b0;
      e_rck  = (c > shift_end) && (c < p);
      e_done = (c == p - 1);
      e_busy = (c < p);
      if ({o_sck, o_ser, o_rck, o_done, o_busy} !== {e_sck, e_ser, e_rck, e_done, e_busy})
        wave_bad++;
      if (o_sck && !prev_sck) begin
        bits = {bits[14:0], o_ser};
        rises++;
      end
      prev_sck = o_sck;
      if (c == p) st_end = o_st;
    end
    check($sformatf("v%0d ack at cycle 1", id), 32'(ack_first), 32'(2'b01 << v.grant));
    check($sformatf("v%0d grant_id", id), 32'(gid_first), 32'(v.grant));
    check($sformatf("v%0d stray ack cycles", id), ack_bad, 0);
    check($sformatf("v%0d sck/ser/rck/done/busy waveform cycles off", id), wave_bad, 0);
    check($sformatf("v%0d bits on sck rise", id), 32'(bits), 32'(fexp));
    check($sformatf("v%0d sck rises", id), rises, 16);
    check($sformatf("v%0d chain latched", id), 32'(o_lat), 32'(fexp));
    check($sformatf("v%0d state at period end", id), 32'(st_end), 32'(IDLE));
    if (v.drop) begin
      idle_bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (o_ack != 2'b00 || o_busy || o_st != IDLE) idle_bad++;
      end
      check($sformatf("v%0d quiet idle after drop", id), idle_bad, 0);
    end
  endtask

  vec_t vecs[10];
  vec_t post;

  initial begin
    int rises, rck_before;
    logic prev;

    vecs[0] = '{0, 2'b01, 16'hA55A, 16'h0000, 1'b1, 1'b0, 0};
    vecs[1] = '{0, 2'b10, 16'h0000, 16'h3C0F, 1'b1, 1'b0, 1};
    vecs[2] = '{0, 2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0, 0};
    vecs[3] = '{0, 2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0, G_ALT};
    vecs[4] = '{0, 2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0, 0};
    vecs[5] = '{0, 2'b11, 16'h1111, 16'h2222, 1'b1, 1'b0, G_ALT};
    vecs[6] = '{0, 2'b01, 16'h8001, 16'h7777, 1'b1, 1'b1, 0};
    vecs[7] = '{0, 2'b10, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1};
    vecs[8] = '{1, 2'b01, 16'hC3A5, 16'h0000, 1'b1, 1'b0, 0};
    vecs[9] = '{1, 2'b11, 16'h0F0F, 16'h5A96, 1'b1, 1'b0, G_ALT};
    post    = '{0, 2'b01, 16'hF0F0, 16'h0000, 1'b1, 1'b0, 0};

    bus0.req = '0; bus0.frame = '0;
    bus1.req = '0; bus1.frame = '0;

    // reset values
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs dut0", {25'd0, sck0, rck0, ser0, bus0.ack, bus0.done, bus0.busy, bus0.grant_id}, 0);
    check("reset outputs dut1", {25'd0, sck1, rck1, ser1, bus1.ack, bus1.done, bus1.busy, bus1.grant_id}, 0);
    check("reset state dut0", 32'(st0), 32'(IDLE));
    check("reset state dut1", 32'(st1), 32'(IDLE));
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // reset after the fifth sck rise: pins drop at once, nothing latched
    sel = 0;
    bus0.frame = {16'h0000, 16'hF0F0};
    bus0.req   = 2'b01;
    rises = 0;
    prev  = 1'b0;
    for (int c = 0; c < 200 && rises < 5; c++) begin
      @(negedge clk);
      if (sck0 && !prev) rises++;
      prev = sck0;
    end
    check("midrst sck rises before reset", rises, 5);
    rck_before = rck_rises0;
    #2 rstn = 1'b0;
    #1;
    check("midrst outputs", {25'd0, sck0, rck0, ser0, bus0.ack, bus0.done, bus0.busy, bus0.grant_id}, 0);
    check("midrst state", 32'(st0), 32'(IDLE));
    @(negedge clk);
    check("midrst rck pulses", rck_rises0 - rck_before, 0);
    check("midrst chain keeps previous frame", 32'(lat0), 32'h0000FFFF);
    rstn = 1'b1;
    run_vec(post, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
